progmem_arbiter: RTL and testbench

- Shares the single-port program memory between two requesters: the pipeline instruction-fetch stage (read-only) and the loader/debug port (read/write, used to download or patch programs).
- Sits between those requesters and the program memory; drives the memory's MEMREAD/MEMWRITE/ADDR/WRITE_DATA and routes its registered READ_DATA back to whichever requester owns the access.
- Loader has priority, bounded by a starvation counter; a lock input gives the loader exclusive ownership and stalls the pipeline.

---
 rtl/progmem_arb_pkg.sv | 24 ++
 rtl/progmem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_progmem_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/progmem_arb_pkg.sv
// progmem_arb_pkg
// Shared encodings for the program-memory arbiter.
//   owner_e     : which requester owns the response in the cycle after a grant
//   arb_state_e : arbitration FSM states
//   NOP_WORD    : instruction word the fetch side substitutes while stalled
//   CNT_W       : width of the starvation counter (STARVE_MAX up to 15)
package progmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LOAD  = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    ST_LPRI   = 2'd0,
    ST_FFORCE = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

  localparam logic [31:0] NOP_WORD = 32'hF800_0000;
  localparam int          CNT_W    = 4;

endpackage

// File: rtl/progmem_arbiter.sv
// progmem_arbiter
// Shares the single-port program memory between the instruction-fetch stage
// (read-only) and the loader/debug port (read/write). One grant per cycle,
// memory controls driven combinationally from the winner, response one cycle
// later from the memory's registered READ_DATA.
//
// Ports
//   CLK, RESET                 clock, async active-high reset
//   F_REQ/F_ADDR               fetch read request
//   F_GNT/F_RVALID/F_RDATA     fetch grant (comb) and response
//   L_REQ/L_WE/L_ADDR/L_WDATA  loader request
//   L_LOCK                     loader exclusive mode
//   L_GNT/L_RVALID/L_RDATA     loader grant (comb) and response
//   M_*                        program memory interface
//   STALL                      fetch pending-not-granted, or locked
//   ERR_ADDR                   out-of-range pulse aligned with RVALID
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_LPRI   | loader wins ties; counts loader wins while fetch waits
// ST_FFORCE | fetch wins this cycle (starvation limit reached)
// ST_LOCKED | L_LOCK high: loader only; behaves as LPRI (count 0) on release
module progmem_arbiter
  import progmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_DEPTH  = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              F_REQ,
  input  logic [ADDR_W-1:0] F_ADDR,
  output logic              F_GNT,
  output logic              F_RVALID,
  output logic [DATA_W-1:0] F_RDATA,
  input  logic              L_REQ,
  input  logic              L_WE,
  input  logic [ADDR_W-1:0] L_ADDR,
  input  logic [DATA_W-1:0] L_WDATA,
  input  logic              L_LOCK,
  output logic              L_GNT,
  output logic              L_RVALID,
  output logic [DATA_W-1:0] L_RDATA,
  output logic              M_MEMREAD,
  output logic              M_MEMWRITE,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic [DATA_W-1:0] M_WRITE_DATA,
  input  logic [DATA_W-1:0] M_READ_DATA,
  output logic              STALL,
  output logic              ERR_ADDR
);

  localparam logic [ADDR_W-1:0] DEPTH   = ADDR_W'(MEM_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_e        r_state;
  logic [CNT_W-1:0]  r_starve_cnt;
  owner_e            r_owner;
  logic              r_oor;
  logic [DATA_W-1:0] r_f_rdata;
  logic [DATA_W-1:0] r_l_rdata;

  logic              w_f_gnt;
  logic              w_l_gnt;
  logic              w_f_oor;
  logic              w_l_oor;
  logic              w_gnt_oor;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [DATA_W-1:0] w_resp_data;

  assign w_f_oor   = (F_ADDR >= DEPTH);
  assign w_l_oor   = (L_ADDR >= DEPTH);
  assign w_cnt_inc = r_starve_cnt + CNT_W'(1);

  // Grant decision. Lock overrides the FSM so fetch is blocked from the very
  // cycle L_LOCK rises, not one cycle later.
  always_comb begin
    w_f_gnt = 1'b0;
    w_l_gnt = 1'b0;
    if (!RESET) begin
      if (L_LOCK) begin
        w_l_gnt = L_REQ;
      end else if (r_state == ST_FFORCE) begin
        w_f_gnt = F_REQ;
        w_l_gnt = L_REQ && !F_REQ;
      end else begin
        w_l_gnt = L_REQ;
        w_f_gnt = F_REQ && !L_REQ;
      end
    end
  end

  // Memory side. Out-of-range accesses are still granted (so the requester
  // gets an error response) but never touch the memory.
  always_comb begin
    M_MEMREAD    = 1'b0;
    M_MEMWRITE   = 1'b0;
    M_ADDR       = '0;
    M_WRITE_DATA = '0;
    w_gnt_oor    = 1'b0;
    if (w_l_gnt) begin
      M_ADDR    = L_ADDR;
      w_gnt_oor = w_l_oor;
      if (L_WE) begin
        M_WRITE_DATA = L_WDATA;
        M_MEMWRITE   = !w_l_oor;
      end else begin
        M_MEMREAD    = !w_l_oor;
      end
    end else if (w_f_gnt) begin
      M_ADDR    = F_ADDR;
      w_gnt_oor = w_f_oor;
      M_MEMREAD = !w_f_oor;
    end
  end

  assign F_GNT = w_f_gnt;
  assign L_GNT = w_l_gnt;
  assign STALL = L_LOCK || (F_REQ && !w_f_gnt);

  // Response side: memory data is only valid in the response cycle, so the
  // owner's RDATA is taken straight from it and captured for holding after.
  assign F_RVALID    = (r_owner == OWN_FETCH);
  assign L_RVALID    = (r_owner == OWN_LOAD);
  assign ERR_ADDR    = r_oor;
  assign w_resp_data = r_oor ? '0 : M_READ_DATA;
  assign F_RDATA     = F_RVALID ? w_resp_data : r_f_rdata;
  assign L_RDATA     = L_RVALID ? w_resp_data : r_l_rdata;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= ST_LPRI;
      r_starve_cnt <= '0;
      r_owner      <= OWN_NONE;
      r_oor        <= 1'b0;
      r_f_rdata    <= '0;
      r_l_rdata    <= '0;
    end else begin
      if (F_RVALID) r_f_rdata <= w_resp_data;
      if (L_RVALID) r_l_rdata <= w_resp_data;

      if (w_l_gnt)      r_owner <= OWN_LOAD;
      else if (w_f_gnt) r_owner <= OWN_FETCH;
      else              r_owner <= OWN_NONE;
      r_oor <= w_gnt_oor;

      if (L_LOCK) begin
        r_state      <= ST_LOCKED;
        r_starve_cnt <= '0;
      end else begin
        case (r_state)
          ST_FFORCE: begin
            r_state      <= ST_LPRI;
            r_starve_cnt <= '0;
          end
          default: begin
            // LPRI, and LOCKED on the cycle the lock drops (count already 0)
            r_state <= ST_LPRI;
            if (w_l_gnt && F_REQ) begin
              r_starve_cnt <= w_cnt_inc;
              if (w_cnt_inc == CNT_MAX) r_state <= ST_FFORCE;
            end else begin
              r_starve_cnt <= '0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_progmem_arbiter.sv
// Self-checking bench for progmem_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the arbitration rules and a shadow copy of memory.
module tb_progmem_arbiter;
  import progmem_arb_pkg::*;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_DEPTH  = 32;
  localparam int STARVE_MAX = 4;

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic              F_REQ = 1'b0;
  logic [ADDR_W-1:0] F_ADDR = '0;
  logic              F_GNT, F_RVALID;
  logic [DATA_W-1:0] F_RDATA;
  logic              L_REQ = 1'b0;
  logic              L_WE = 1'b0;
  logic [ADDR_W-1:0] L_ADDR = '0;
  logic [DATA_W-1:0] L_WDATA = '0;
  logic              L_LOCK = 1'b0;
  logic              L_GNT, L_RVALID;
  logic [DATA_W-1:0] L_RDATA;
  logic              M_MEMREAD, M_MEMWRITE;
  logic [ADDR_W-1:0] M_ADDR;
  logic [DATA_W-1:0] M_WRITE_DATA;
  logic [DATA_W-1:0] M_READ_DATA;
  logic              STALL, ERR_ADDR;

  int n_cmp  = 0;
  int n_fail = 0;

  progmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .F_REQ(F_REQ), .F_ADDR(F_ADDR), .F_GNT(F_GNT), .F_RVALID(F_RVALID), .F_RDATA(F_RDATA),
    .L_REQ(L_REQ), .L_WE(L_WE), .L_ADDR(L_ADDR), .L_WDATA(L_WDATA), .L_LOCK(L_LOCK),
    .L_GNT(L_GNT), .L_RVALID(L_RVALID), .L_RDATA(L_RDATA),
    .M_MEMREAD(M_MEMREAD), .M_MEMWRITE(M_MEMWRITE), .M_ADDR(M_ADDR),
    .M_WRITE_DATA(M_WRITE_DATA), .M_READ_DATA(M_READ_DATA),
    .STALL(STALL), .ERR_ADDR(ERR_ADDR)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] prog_word(input int i);
    return (i == 1) ? 32'h2021_000F : NOP_WORD;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- program memory (registered read, echoes writes) --------
  logic [31:0] mem [MEM_DEPTH];
  logic [31:0] mem_rdata;
  assign M_READ_DATA = mem_rdata;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mem_rdata <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= prog_word(i);
    end else if (M_MEMWRITE && M_ADDR < MEM_DEPTH) begin
      mem[M_ADDR[4:0]] <= M_WRITE_DATA;
      mem_rdata        <= M_WRITE_DATA;
    end else if (M_MEMREAD && M_ADDR < MEM_DEPTH) begin
      mem_rdata <= mem[M_ADDR[4:0]];
    end
  end

  // ---------------- behavioural model ---------------------------------------
  int          m_starve = 0;   // loader wins in a row while fetch waited
  bit          m_fetch_turn = 0;
  bit          p_valid = 0, p_fetch = 0, p_err = 0;
  logic [31:0] p_data = '0;
  logic [31:0] m_fhold = '0, m_lhold = '0;
  logic [31:0] shadow [MEM_DEPTH];

  always @(posedge RESET) begin
    m_starve     = 0;
    m_fetch_turn = 0;
    p_valid      = 0;
    m_fhold      = '0;
    m_lhold      = '0;
    for (int i = 0; i < MEM_DEPTH; i++) shadow[i] = prog_word(i);
  end

  always @(negedge CLK) begin : compare
    int          winner;         // 0 none, 1 fetch, 2 loader
    logic [31:0] ea, ewd, efd, eld;
    bit          e_oor, erd, ewr, ef, el;

    efd = (p_valid && p_fetch)  ? p_data : m_fhold;
    eld = (p_valid && !p_fetch) ? p_data : m_lhold;
    chk("f_rvalid", 64'(F_RVALID), 64'(p_valid && p_fetch));
    chk("l_rvalid", 64'(L_RVALID), 64'(p_valid && !p_fetch));
    chk("err_addr", 64'(ERR_ADDR), 64'(p_valid && p_err));
    chk("f_rdata",  64'(F_RDATA),  64'(efd));
    chk("l_rdata",  64'(L_RDATA),  64'(eld));
    m_fhold = efd;
    m_lhold = eld;

    winner = 0;
    if (!RESET) begin
      if (L_LOCK)                      winner = L_REQ ? 2 : 0;
      else if (m_fetch_turn && F_REQ)  winner = 1;
      else if (L_REQ)                  winner = 2;
      else if (F_REQ)                  winner = 1;
    end
    ef = (winner == 1);
    el = (winner == 2);

    ea    = el ? L_ADDR : (ef ? F_ADDR : 32'h0);
    e_oor = (winner != 0) && (ea >= MEM_DEPTH);
    ewr   = el && L_WE && !e_oor;
    erd   = (ef || (el && !L_WE)) && !e_oor;
    ewd   = (el && L_WE) ? L_WDATA : 32'h0;

    chk("f_gnt",      64'(F_GNT),        64'(ef));
    chk("l_gnt",      64'(L_GNT),        64'(el));
    chk("stall",      64'(STALL),        64'(L_LOCK || (F_REQ && !ef)));
    chk("m_memread",  64'(M_MEMREAD),    64'(erd));
    chk("m_memwrite", 64'(M_MEMWRITE),   64'(ewr));
    chk("m_addr",     64'(M_ADDR),       64'(ea));
    chk("m_wdata",    64'(M_WRITE_DATA), 64'(ewd));

    p_valid = (winner != 0);
    p_fetch = ef;
    p_err   = e_oor;
    if (ewr) begin
      shadow[ea[4:0]] = L_WDATA;
      p_data = L_WDATA;
    end else if (erd) begin
      p_data = shadow[ea[4:0]];
    end else begin
      p_data = 32'h0;
    end

    if (RESET || L_LOCK || m_fetch_turn) begin
      m_starve     = 0;
      m_fetch_turn = 0;
    end else if (el && F_REQ) begin
      m_starve++;
      if (m_starve == STARVE_MAX) begin
        m_fetch_turn = 1;
        m_starve     = 0;
      end
    end else begin
      m_starve = 0;
    end
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
    #1;
  endtask

  initial begin
    logic exp_f;
    #1 RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;

    smp();
    chk("rst_ctl",   64'({F_RVALID, L_RVALID, ERR_ADDR, F_GNT, L_GNT, STALL, M_MEMREAD, M_MEMWRITE}), 64'h0);
    chk("rst_rdata", {F_RDATA, L_RDATA}, 64'h0);

    // fetch only, reset program
    cyc(); F_REQ = 1'b1; F_ADDR = 32'd0;
    smp(); chk("fo_gnt0", 64'(F_GNT), 64'h1);
    cyc(); F_ADDR = 32'd1;
    smp(); chk("fo_data0", 64'({F_RVALID, F_RDATA}), 64'({1'b1, NOP_WORD}));
    cyc(); F_ADDR = 32'd2;
    smp(); chk("fo_data1", 64'({F_RVALID, F_RDATA}), 64'({1'b1, 32'h2021_000F}));
    cyc(); F_REQ = 1'b0;
    smp(); chk("fo_data2", 64'({F_RVALID, F_RDATA}), 64'({1'b1, NOP_WORD}));

    // loader write, then fetch reads it back
    cyc(); L_REQ = 1'b1; L_WE = 1'b1; L_ADDR = 32'd7; L_WDATA = 32'h2002_0005;
    smp(); chk("wr_ctl", 64'({L_GNT, M_MEMWRITE, M_MEMREAD}), 64'b110);
    cyc(); L_REQ = 1'b0; L_WE = 1'b0; F_REQ = 1'b1; F_ADDR = 32'd7;
    smp(); chk("wr_echo", 64'({L_RVALID, L_RDATA}), 64'({1'b1, 32'h2002_0005}));
    cyc(); F_REQ = 1'b0;
    smp(); chk("rd_back", 64'({F_RVALID, F_RDATA}), 64'({1'b1, 32'h2002_0005}));

    // contention: L,L,L,L,F,L,L,L,L,F
    cyc(); L_REQ = 1'b1; L_ADDR = 32'd3; F_REQ = 1'b1; F_ADDR = 32'd4;
    for (int i = 0; i < 10; i++) begin
      smp();
      exp_f = (i == 4 || i == 9);
      chk("cont_gnt", 64'({F_GNT, L_GNT, STALL}), 64'({exp_f, !exp_f, !exp_f}));
      cyc();
    end
    L_REQ = 1'b0; F_REQ = 1'b0;

    // lock for 10 cycles with fetch pending
    cyc(); F_REQ = 1'b1; L_LOCK = 1'b1;
    for (int i = 0; i < 10; i++) begin
      smp(); chk("lock_stall", 64'({F_GNT, STALL}), 64'b01);
      cyc();
    end
    L_LOCK = 1'b0;
    smp(); chk("unlock_fgnt", 64'(F_GNT), 64'h1);

    // out of range loader read
    cyc(); F_REQ = 1'b0; L_REQ = 1'b1; L_WE = 1'b0; L_ADDR = 32'd40;
    smp(); chk("oor_ctl", 64'({L_GNT, M_MEMREAD, M_MEMWRITE}), 64'b100);
    cyc(); L_REQ = 1'b0;
    smp(); chk("oor_resp", 64'({L_RVALID, ERR_ADDR, L_RDATA}), 64'({2'b11, 32'h0}));

    // reset during a granted fetch
    cyc(); F_REQ = 1'b1; F_ADDR = 32'd5;
    smp(); chk("rst_mid_gnt", 64'(F_GNT), 64'h1);
    RESET = 1'b1; F_REQ = 1'b0;
    cyc();
    smp();
    chk("rst_mid_ctl", 64'({F_RVALID, L_RVALID, ERR_ADDR, F_GNT, L_GNT, STALL, M_MEMREAD, M_MEMWRITE}), 64'h0);
    chk("rst_mid_rdata", {F_RDATA, L_RDATA}, 64'h0);
    cyc(); RESET = 1'b0;
    smp(); chk("rst_no_resp", 64'(F_RVALID), 64'h0);

    // randomized traffic, checked by the compare process each cycle
    for (int n = 0; n < 3000; n++) begin
      cyc();
      RESET   = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) L_LOCK = !L_LOCK;
      L_REQ   = ($urandom_range(0, 1) == 1);
      L_WE    = ($urandom_range(0, 1) == 1);
      L_ADDR  = $urandom_range(0, 39);
      L_WDATA = $urandom();
      F_REQ   = ($urandom_range(0, 3) != 0);
      F_ADDR  = $urandom_range(0, 39);
    end
    cyc();
    RESET = 1'b0; L_LOCK = 1'b0; L_REQ = 1'b0; F_REQ = 1'b0;
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
